// File: rtl/veripark_pkg.sv
// Shared definitions for the parking_system entrance front end: indicator codes,
// terminal FSM states and a sizing helper.
package veripark_pkg;

    localparam logic [2:0] IND_IDLE           = 3'b000;
    localparam logic [2:0] IND_PASSWORD_CHECK = 3'b010;
    localparam logic [2:0] IND_ENTRY_GRANTED  = 3'b001;
    localparam logic [2:0] IND_EXIT_GRANTED   = 3'b100;
    localparam logic [2:0] IND_FULL           = 3'b110;

    // Reference password of the attached parking_system; only benches use it.
    localparam logic [3:0] CORRECT_PASSWORD = 4'b1001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_KEY,
        ST_WAIT_RESP,
        ST_GRANTED,
        ST_DENIED,
        ST_LOCKOUT
    } et_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Loadable down-counter that stops at zero; one instance is time-shared by the
// response-timeout, gate-hold and lockout phases of entry_terminal.
module entry_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (en && (cnt_q != '0))
            cnt_q <= cnt_q - ONE;
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/entry_terminal.sv
// Entrance-lane front end: turns loop-detector presence plus one keypad word into a
// request to parking_system, then opens the barrier or counts failures / locks out.
module entry_terminal
    import veripark_pkg::*;
#(
    parameter int PASS_W         = 4,
    parameter int MAX_TRIES      = 3,
    parameter int RESP_DELAY     = 2,
    parameter int RESP_TIMEOUT   = 16,
    parameter int HOLD_CYCLES    = 8,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              car_present,
    input  logic              key_valid,
    input  logic [PASS_W-1:0] key_code,
    input  logic              GREEN_LED,
    input  logic              RED_LED,
    input  logic [2:0]        indicator,
    output logic              sensor_entrance,
    output logic [PASS_W-1:0] password,
    output logic              gate_open,
    output logic              denied,
    output logic              lot_full,
    output logic              timeout_err,
    output logic              locked,
    output logic [1:0]        tries_left
);

    localparam int TMR_MAX = max3(RESP_TIMEOUT, HOLD_CYCLES, LOCKOUT_CYCLES);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    // Every phase loads N-1 so the state lasts exactly N cycles ending at count 0.
    localparam logic [TMR_W-1:0] RESP_LD  = TMR_W'(RESP_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LD  = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LIVE_MAX = TMR_W'(RESP_TIMEOUT - 1 - RESP_DELAY);
    localparam logic [1:0]       TRIES_MAX = 2'(MAX_TRIES);

    et_state_e         state_q, state_d;
    logic [1:0]        tries_q, tries_d;
    logic [PASS_W-1:0] pw_q, pw_d;
    logic              sensor_q, gate_q, denied_q, lot_full_q, timeout_q, locked_q;
    logic              lot_full_d, timeout_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val, tmr_cnt;
    logic              tmr_zero;
    logic              led_live;

    entry_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .en       (1'b1),
        .load_val (tmr_val),
        .count    (tmr_cnt),
        .zero     (tmr_zero)
    );

    // LEDs left over from a previous request are masked for the first RESP_DELAY cycles.
    assign led_live = (tmr_cnt <= LIVE_MAX);

    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        pw_d       = pw_q;
        lot_full_d = 1'b0;
        timeout_d  = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        case (state_q)
            ST_IDLE: begin
                if (car_present) state_d = ST_WAIT_KEY;
            end
            ST_WAIT_KEY: begin
                if (!car_present) begin
                    state_d = ST_IDLE;
                end else if (key_valid) begin
                    pw_d    = key_code;
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (led_live && RED_LED) begin
                    state_d = ST_DENIED;
                    if (indicator == IND_FULL)
                        lot_full_d = 1'b1;
                    else if (tries_q != 2'd0)
                        tries_d = tries_q - 2'd1;
                end else if (led_live && GREEN_LED) begin
                    state_d = ST_GRANTED;
                    tries_d = TRIES_MAX;
                end else if (tmr_zero) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_GRANTED: begin
                // Hold countdown only runs once the car has left the loop.
                if (car_present) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end else if (tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DENIED: begin
                if (!lot_full_q && (tries_q == 2'd0))
                    state_d = ST_LOCKOUT;
                else if (car_present)
                    state_d = ST_WAIT_KEY;
                else
                    state_d = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    tries_d = TRIES_MAX;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            tmr_load = 1'b1;
            case (state_d)
                ST_WAIT_RESP: tmr_val = RESP_LD;
                ST_GRANTED:   tmr_val = HOLD_LD;
                ST_LOCKOUT:   tmr_val = LOCK_LD;
                default:      tmr_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tries_q    <= TRIES_MAX;
            pw_q       <= '0;
            sensor_q   <= 1'b0;
            gate_q     <= 1'b0;
            denied_q   <= 1'b0;
            lot_full_q <= 1'b0;
            timeout_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tries_q    <= tries_d;
            pw_q       <= pw_d;
            sensor_q   <= (state_d == ST_WAIT_RESP);
            gate_q     <= (state_d == ST_GRANTED);
            denied_q   <= (state_d == ST_DENIED);
            lot_full_q <= lot_full_d;
            timeout_q  <= timeout_d;
            locked_q   <= (state_d == ST_LOCKOUT);
        end
    end

    assign sensor_entrance = sensor_q;
    assign password        = pw_q;
    assign gate_open       = gate_q;
    assign denied          = denied_q;
    assign lot_full        = lot_full_q;
    assign timeout_err     = timeout_q;
    assign locked          = locked_q;
    assign tries_left      = tries_q;

endmodule

// File: tb/tb_entry_terminal.sv
// Scenario bench for entry_terminal: expected passwords and tries are queued when
// stimulus is driven and popped when the DUT raises the matching request/verdict.
module tb_entry_terminal;
    import veripark_pkg::*;

    logic       clk = 1'b0;
    logic       reset, car_present, key_valid, GREEN_LED, RED_LED;
    logic [3:0] key_code;
    logic [2:0] indicator;
    logic       sensor_entrance, gate_open, denied, lot_full, timeout_err, locked;
    logic [3:0] password;
    logic [1:0] tries_left;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] sb_pw[$];
    logic [1:0] sb_tries[$];
    logic [1:0] m_tries;
    logic [3:0] want_pw;
    logic [1:0] want_tr;

    entry_terminal #(
        .PASS_W(4), .MAX_TRIES(3), .RESP_DELAY(2), .RESP_TIMEOUT(16),
        .HOLD_CYCLES(8), .LOCKOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset), .car_present(car_present), .key_valid(key_valid),
        .key_code(key_code), .GREEN_LED(GREEN_LED), .RED_LED(RED_LED),
        .indicator(indicator), .sensor_entrance(sensor_entrance), .password(password),
        .gate_open(gate_open), .denied(denied), .lot_full(lot_full),
        .timeout_err(timeout_err), .locked(locked), .tries_left(tries_left)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle key strobe that is expected to become a request.
    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        sb_pw.push_back(k);
        step();
        key_valid = 1'b0;
    endtask

    task automatic pop_pw();
        want_pw = 4'hx;
        if (sb_pw.size() > 0) want_pw = sb_pw.pop_front();
    endtask

    task automatic pop_tries();
        want_tr = 2'bxx;
        if (sb_tries.size() > 0) want_tr = sb_tries.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b1; car_present = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        GREEN_LED = 1'b0; RED_LED = 1'b0; indicator = IND_IDLE;
        step(2);
        n_cmp++;
        if ({sensor_entrance, password, gate_open, denied, lot_full, timeout_err, locked, tries_left} !== 12'h003) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 003", {sensor_entrance, password, gate_open, denied, lot_full, timeout_err, locked, tries_left});
        end
        reset = 1'b0;
        m_tries = 2'd3;
        step();
    endtask

    task automatic test_grant();
        car_present = 1'b1;
        step(2);
        press(CORRECT_PASSWORD);
        pop_pw();
        n_cmp++;
        if (sensor_entrance !== 1'b1) begin n_bad++; $display("FAIL grant_sensor_lat1: got %b want 1", sensor_entrance); end
        n_cmp++;
        if (password !== want_pw) begin n_bad++; $display("FAIL grant_password: got %h want %h", password, want_pw); end
        step(2);
        GREEN_LED = 1'b1;
        step();
        GREEN_LED = 1'b0;
        n_cmp++;
        if ({sensor_entrance, gate_open} !== 2'b01) begin n_bad++; $display("FAIL grant_open: got %b want 01", {sensor_entrance, gate_open}); end
        n_cmp++;
        if (tries_left !== m_tries) begin n_bad++; $display("FAIL grant_tries: got %0d want %0d", tries_left, m_tries); end
        step(3);
        car_present = 1'b0;
        step(7);
        n_cmp++;
        if (gate_open !== 1'b1) begin n_bad++; $display("FAIL hold_7: got %b want 1", gate_open); end
        step();
        n_cmp++;
        if (gate_open !== 1'b0) begin n_bad++; $display("FAIL hold_8: got %b want 0", gate_open); end
    endtask

    task automatic test_wrong_keys();
        int  cnt;
        bit  saw;
        car_present = 1'b1;
        step(2);
        for (int i = 0; i < 3; i++) begin
            press(4'b1010);
            pop_pw();
            n_cmp++;
            if ({sensor_entrance, password} !== {1'b1, want_pw}) begin n_bad++; $display("FAIL wrong_req%0d: got %b_%h want 1_%h", i, sensor_entrance, password, want_pw); end
            step(2);
            RED_LED = 1'b1;
            m_tries = m_tries - 2'd1;
            sb_tries.push_back(m_tries);
            step();
            RED_LED = 1'b0;
            pop_tries();
            n_cmp++;
            if ({denied, lot_full, tries_left} !== {2'b10, want_tr}) begin n_bad++; $display("FAIL wrong_deny%0d: got %b want 10%b", i, {denied, lot_full, tries_left}, want_tr); end
            step();
            n_cmp++;
            if ({denied, locked} !== ((i < 2) ? 2'b00 : 2'b01)) begin n_bad++; $display("FAIL wrong_after%0d: got %b", i, {denied, locked}); end
        end
        cnt = 0; saw = 0;
        while (locked === 1'b1 && cnt < 200) begin
            cnt++;
            key_code  = CORRECT_PASSWORD;
            key_valid = (cnt == 10);
            if (sensor_entrance !== 1'b0) saw = 1;
            step();
        end
        key_valid = 1'b0;
        n_cmp++;
        if (cnt != 64) begin n_bad++; $display("FAIL lockout_len: got %0d want 64", cnt); end
        n_cmp++;
        if (saw) begin n_bad++; $display("FAIL lockout_key: got sensor 1 want 0"); end
        m_tries = 2'd3;
        n_cmp++;
        if (tries_left !== m_tries) begin n_bad++; $display("FAIL lockout_reload: got %0d want %0d", tries_left, m_tries); end
    endtask

    task automatic test_full_lot();
        step(2);
        press(CORRECT_PASSWORD);
        pop_pw();
        n_cmp++;
        if ({sensor_entrance, password} !== {1'b1, want_pw}) begin n_bad++; $display("FAIL full_req: got %b_%h want 1_%h", sensor_entrance, password, want_pw); end
        indicator = IND_FULL;
        step(2);
        RED_LED = 1'b1;
        sb_tries.push_back(m_tries);
        step();
        RED_LED = 1'b0;
        indicator = IND_IDLE;
        pop_tries();
        n_cmp++;
        if ({denied, lot_full, tries_left} !== {2'b11, want_tr}) begin n_bad++; $display("FAIL full_deny: got %b want 11%b", {denied, lot_full, tries_left}, want_tr); end
        step();
        n_cmp++;
        if ({denied, lot_full, locked} !== 3'b000) begin n_bad++; $display("FAIL full_pulse: got %b want 000", {denied, lot_full, locked}); end
    endtask

    task automatic test_stale_timeout();
        int cnt;
        bit saw_gate;
        GREEN_LED = 1'b1;
        press(4'b0110);
        pop_pw();
        // A request at latency 1 also shows the full-lot denial returned to WAIT_KEY.
        n_cmp++;
        if ({sensor_entrance, password} !== {1'b1, want_pw}) begin n_bad++; $display("FAIL full_to_waitkey: got %b_%h want 1_%h", sensor_entrance, password, want_pw); end
        cnt = 1; saw_gate = 0;
        step();
        GREEN_LED = 1'b0;
        while (sensor_entrance === 1'b1 && cnt < 40) begin
            cnt++;
            if (gate_open !== 1'b0) saw_gate = 1;
            step();
        end
        n_cmp++;
        if (cnt != 16) begin n_bad++; $display("FAIL timeout_len: got %0d want 16", cnt); end
        n_cmp++;
        if ({timeout_err, gate_open, denied, saw_gate} !== 4'b1000) begin n_bad++; $display("FAIL timeout_pulse: got %b want 1000", {timeout_err, gate_open, denied, saw_gate}); end
        n_cmp++;
        if (tries_left !== m_tries) begin n_bad++; $display("FAIL timeout_tries: got %0d want %0d", tries_left, m_tries); end
        step();
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL timeout_one_cycle: got %b want 0", timeout_err); end
    endtask

    task automatic test_both_leds();
        bit saw_gate;
        step();
        press(4'b1100);
        pop_pw();
        n_cmp++;
        if ({sensor_entrance, password} !== {1'b1, want_pw}) begin n_bad++; $display("FAIL both_req: got %b_%h want 1_%h", sensor_entrance, password, want_pw); end
        step(2);
        GREEN_LED = 1'b1; RED_LED = 1'b1;
        m_tries = m_tries - 2'd1;
        sb_tries.push_back(m_tries);
        step();
        GREEN_LED = 1'b0; RED_LED = 1'b0;
        pop_tries();
        n_cmp++;
        if ({denied, gate_open, tries_left} !== {2'b10, want_tr}) begin n_bad++; $display("FAIL both_deny: got %b want 10%b", {denied, gate_open, tries_left}, want_tr); end
        saw_gate = 0;
        for (int i = 0; i < 5; i++) begin
            if (gate_open !== 1'b0) saw_gate = 1;
            step();
        end
        n_cmp++;
        if (saw_gate) begin n_bad++; $display("FAIL both_no_gate: got gate 1 want 0"); end
    endtask

    task automatic test_reset_mid();
        press(4'b0101);
        pop_pw();
        n_cmp++;
        if ({sensor_entrance, password} !== {1'b1, want_pw}) begin n_bad++; $display("FAIL mid_req: got %b_%h want 1_%h", sensor_entrance, password, want_pw); end
        step();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({sensor_entrance, password, gate_open} !== 6'b0) begin n_bad++; $display("FAIL mid_async: got %b want 000000", {sensor_entrance, password, gate_open}); end
        car_present = 1'b0;
        step();
        reset = 1'b0;
        m_tries = 2'd3;
        step();
        n_cmp++;
        if ({sensor_entrance, password, gate_open, denied, lot_full, timeout_err, locked, tries_left} !== 12'h003) begin
            n_bad++;
            $display("FAIL mid_release: got %h want 003", {sensor_entrance, password, gate_open, denied, lot_full, timeout_err, locked, tries_left});
        end
        // From IDLE a key in the same cycle as arrival must be dropped.
        car_present = 1'b1; key_code = 4'b0111; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        step();
        n_cmp++;
        if (sensor_entrance !== 1'b0) begin n_bad++; $display("FAIL idle_key_ignored: got %b want 0", sensor_entrance); end
        press(CORRECT_PASSWORD);
        pop_pw();
        n_cmp++;
        if ({sensor_entrance, password} !== {1'b1, want_pw}) begin n_bad++; $display("FAIL after_reset_req: got %b_%h want 1_%h", sensor_entrance, password, want_pw); end
        step(2);
        GREEN_LED = 1'b1;
        step();
        GREEN_LED = 1'b0;
        car_present = 1'b0;
        n_cmp++;
        if (gate_open !== 1'b1) begin n_bad++; $display("FAIL after_reset_grant: got %b want 1", gate_open); end
        step(8);
        n_cmp++;
        if (gate_open !== 1'b0) begin n_bad++; $display("FAIL after_reset_hold: got %b want 0", gate_open); end
    endtask

    initial begin
        test_reset();
        test_grant();
        test_wrong_keys();
        test_full_lot();
        test_stale_timeout();
        test_both_leds();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1);
    end

endmodule

// File: doc/entry_terminal.md
Name: entry_terminal

Overview:
- Driver-side front end for parking_system's entrance interface.
- Watches the vehicle loop detector and accepts one keypad word. It then drives sensor_entrance/password into parking_system and waits for the GREEN_LED/RED_LED verdict.
- On a grant it opens the barrier; on a denial it counts failed tries and locks out the keypad.
- Sits between the keypad/loop hardware and parking_system, one instance per entrance lane.

Parameters:
- PASS_W, 4, width of keypad word / password bus.
- MAX_TRIES, 3, wrong-password attempts allowed before lockout (1..3).
- RESP_DELAY, 2, cycles after sensor_entrance rises before LEDs are sampled (masks stale LEDs).
- RESP_TIMEOUT, 16, cycles in WAIT_RESP without any verdict before abort.
- HOLD_CYCLES, 8, cycles the gate stays open after car_present falls.
- LOCKOUT_CYCLES, 64, lockout duration.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- car_present  in  1  loop detector, level, synchronous to clk.
- key_valid  in  1  one-cycle strobe: key_code holds a complete entry.
- key_code  in  PASS_W  keypad word.
- GREEN_LED  in  1  parking_system grant.
- RED_LED  in  1  parking_system deny.
- indicator  in  3  parking_system state code.
- sensor_entrance  out  1  entry request to parking_system.
- password  out  PASS_W  latched key word to parking_system.
- gate_open  out  1  barrier motor enable.
- denied  out  1  one-cycle pulse per denial.
- lot_full  out  1  one-cycle pulse when denial was due to FULL.
- timeout_err  out  1  one-cycle pulse on response timeout.
- locked  out  1  high throughout LOCKOUT.
- tries_left  out  2  remaining attempts.

Behaviour:
Reset:
- All outputs are 0 except tries_left = MAX_TRIES.
- State goes to IDLE and the timer is cleared, taking effect immediately (asynchronous) including mid-request.
- sensor_entrance must drop in the same reset assertion.

FSM, all outputs registered:
- IDLE: car_present=1 -> WAIT_KEY.
- WAIT_KEY:
  - car_present=0 -> IDLE.
  - key_valid=1 -> latch key_code into password and go to WAIT_RESP. sensor_entrance is 1 from the next cycle (latency 1).
  - key_valid with car_present=0 in the same cycle: ignored, go to IDLE.
- WAIT_RESP:
  - sensor_entrance=1 and password stable for the whole state.
  - LEDs are ignored for the first RESP_DELAY cycles; after that they are sampled every cycle.
  - RED_LED=1 -> DENIED. RED wins if both LEDs are 1.
  - GREEN_LED=1 (RED=0) -> GRANTED.
  - Neither LED within RESP_TIMEOUT cycles of entry -> timeout_err pulse, IDLE, tries_left unchanged.
  - key_valid is ignored here.
- GRANTED:
  - sensor_entrance=0 and gate_open=1; tries_left reloads to MAX_TRIES.
  - gate_open stays 1 while car_present=1. After the fall it holds for exactly HOLD_CYCLES, then IDLE.
  - If car_present re-rises during the hold, the hold counter restarts on the next fall.
- DENIED (one cycle):
  - sensor_entrance=0, denied=1.
  - If indicator==FULL (3'b110): lot_full=1 and tries_left unchanged. The next state is WAIT_KEY if car_present, else IDLE.
  - Otherwise tries_left decrements. If the result is 0 -> LOCKOUT; else WAIT_KEY if car_present, else IDLE.
- LOCKOUT:
  - locked=1; keys and car_present are ignored.
  - Lasts exactly LOCKOUT_CYCLES cycles, then tries_left=MAX_TRIES and IDLE.

Protocol rules:
- sensor_entrance is low for at least 1 cycle between successive requests.
- password only changes when sensor_entrance=0.
- tries_left saturates at 0 and never wraps.

Timer:
- Single down-counter sized to max(RESP_TIMEOUT, HOLD_CYCLES, LOCKOUT_CYCLES).
- Loaded on each state entry; terminal count is 0.

Decomposition:
- veripark_pkg:
  - indicator codes: IDLE 3'b000, PASSWORD_CHECK 3'b010, ENTRY_GRANTED 3'b001, EXIT_GRANTED 3'b100, FULL 3'b110.
  - entry_terminal state enum: IDLE, WAIT_KEY, WAIT_RESP, GRANTED, DENIED, LOCKOUT.
  - CORRECT_PASSWORD constant 4'b1001, used by benches only.
- Sub-module entry_timer: loadable down-counter with load value, enable and zero flag. It is shared by the timeout, hold and lockout phases.

Test Plan:
- Grant: reset release; car_present=1; key_valid with key_code=4'b1001; responder raises GREEN 3 cycles later -> sensor_entrance high 1 cycle after key and low after GREEN. gate_open=1; after car_present falls, gate_open=0 exactly 8 cycles later; tries_left=3.
- Three wrong keys (4'b1010), RED each time -> denied pulses ×3 and tries_left 3→2→1→0. locked=1 for exactly 64 cycles, then tries_left=3. A key during lockout produces no sensor_entrance.
- Full lot: indicator=3'b110 with RED_LED=1 -> denied=1 and lot_full=1, tries_left stays 3, state WAIT_KEY.
- Stale LED and timeout: GREEN_LED already 1 at request start and dropped at cycle 1 -> not treated as a grant. No verdict for 16 cycles -> timeout_err pulse, sensor_entrance=0, IDLE.
- Both LEDs high after RESP_DELAY -> DENIED path taken, gate_open never asserted.
- Reset mid-WAIT_RESP -> sensor_entrance, password and gate_open are 0 asynchronously; after release, state IDLE and tries_left=3.
